// File: rtl/ad9363_pkg.sv
// Shared definitions for the AD9363 transmit pattern generator.
// Includes mode encodings, PRBS-15 constants and the per-channel phase stagger.
package ad9363_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_TONE = 2'd1,
    MODE_RAMP = 2'd2,
    MODE_PRBS = 2'd3
  } mode_e;

  // x^15 + x^14 + 1: feedback from state bits 14 and 13
  localparam logic [14:0] PRBS_SEED = 15'h7FFF;
  localparam logic [14:0] PRBS_TAPS = 15'h6000;

  // Phase offset of channel c: c * 2^32 / nch, spreading channels evenly around the circle
  function automatic logic [31:0] chan_phase_offset(input int nch, input int c);
    logic [63:0] num_v;
    logic [63:0] quo_v;
    num_v = {c[31:0], 32'h0000_0000};
    quo_v = num_v / {32'h0000_0000, nch[31:0]};
    return quo_v[31:0];
  endfunction

endpackage

// File: rtl/ad9363_pattern_gen_if.sv
// Configuration and DAC sample bus of the pattern generator.
// The register side uses master; the generator uses slave.
interface ad9363_pattern_gen_if #(
  parameter int DW  = 12,
  parameter int NCH = 2
);
  logic                cfg_en;
  logic [1:0]          cfg_mode;
  logic [31:0]         cfg_phase_inc;
  logic [15:0]         cfg_rate_div;
  logic                dac_valid;
  logic [NCH*DW-1:0]   dac_data_i;
  logic [NCH*DW-1:0]   dac_data_q;
  logic [31:0]         sample_cnt;

  modport master (
    output cfg_en, cfg_mode, cfg_phase_inc, cfg_rate_div,
    input  dac_valid, dac_data_i, dac_data_q, sample_cnt
  );

  modport slave (
    input  cfg_en, cfg_mode, cfg_phase_inc, cfg_rate_div,
    output dac_valid, dac_data_i, dac_data_q, sample_cnt
  );
endinterface

// File: rtl/ad9363_sin_lut.sv
// Full-cycle sine ROM, two registered read ports (1-cycle latency).
// Entry k = round(A*sin(2*pi*k/2^LUT_AW)) with A = 2^(DW-1)-1, built at elaboration.
module ad9363_sin_lut #(
  parameter int DW     = 12,
  parameter int LUT_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] addr_a,
  input  logic [LUT_AW-1:0] addr_b,
  output logic [DW-1:0]     data_a,
  output logic [DW-1:0]     data_b
);

  localparam int  DEPTH    = 32'd2 ** LUT_AW;
  localparam real AMP_R    = real'((32'd2 ** (DW - 32'd1)) - 32'd1);
  localparam real TWO_PI_R = 6.283185307179586;

  logic [DW-1:0] rom_s [DEPTH];

  // Symmetric round-half-away so that entry k+DEPTH/2 is the exact negative of entry k
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real SMP_R = AMP_R * $sin(TWO_PI_R * real'(k) / real'(DEPTH));
    localparam int  VAL   = (SMP_R >= 0.0) ? $rtoi(SMP_R + 0.5) : -$rtoi(0.5 - SMP_R);
    assign rom_s[k] = VAL[DW-1:0];
  end

  // Registered read of both ports
  always_ff @(posedge clk) begin
    if (rst) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      data_a <= rom_s[addr_a];
      data_b <= rom_s[addr_b];
    end
  end

endmodule

// File: rtl/ad9363_pattern_gen.sv
// Multi-channel I/Q test pattern source for the AD9363 DAC path: zero, DDS tone,
// complementary ramp or PRBS-15, one sample per rate tick, two cycles tick-to-output.
module ad9363_pattern_gen
  import ad9363_pkg::*;
#(
  parameter int DW     = 12,
  parameter int NCH    = 2,
  parameter int LUT_AW = 10
) (
  input logic                 clk,
  input logic                 rst,
  ad9363_pattern_gen_if.slave bus
);

  typedef struct packed {
    logic [2*DW-1:0] bits;
    logic [14:0]     state;
  } prbs_t;

  // Runs the LFSR 2*DW steps; the first generated bit lands in the MSB of I
  function automatic prbs_t prbs_run(input logic [14:0] seed);
    prbs_t res_v;
    logic  fb_v;
    res_v.state = seed;
    res_v.bits  = '0;
    for (int b = 0; b < 2 * DW; b++) begin
      fb_v                      = ^(res_v.state & PRBS_TAPS);
      res_v.state               = {res_v.state[13:0], fb_v};
      res_v.bits[2*DW-1-b]      = fb_v;
    end
    return res_v;
  endfunction

  localparam int                QUARTER_I  = 32'd2 ** (LUT_AW - 32'd2);
  localparam logic [LUT_AW-1:0] QUARTER    = QUARTER_I[LUT_AW-1:0];
  localparam int                RAMP_MIN_I = 32'd2 ** (DW - 32'd1);
  localparam logic [DW-1:0]     RAMP_MIN   = RAMP_MIN_I[DW-1:0];

  logic [15:0]         rate_cnt_r;
  logic                tick_s;
  mode_e               mode_sh_r;
  logic [31:0]         acc_r;
  logic [DW-1:0]       ramp_r;
  logic [14:0]         lfsr_r;
  prbs_t               prbs_s;

  logic                vld_p1_r;
  logic [DW-1:0]       ramp_p1_r;
  logic [2*DW-1:0]     prbs_p1_r;

  logic [LUT_AW-1:0]   addr_i_s [NCH];
  logic [LUT_AW-1:0]   addr_q_s [NCH];
  logic [DW-1:0]       lut_i_s  [NCH];
  logic [DW-1:0]       lut_q_s  [NCH];
  logic [DW-1:0]       ramp_c_s [NCH];
  logic [NCH*DW-1:0]   mux_i_s;
  logic [NCH*DW-1:0]   mux_q_s;

  logic                valid_r;
  logic [NCH*DW-1:0]   data_i_r;
  logic [NCH*DW-1:0]   data_q_r;
  logic [31:0]         cnt_r;

  // Terminal count is compared live, so a shrunken divider lets the counter run to 16-bit wrap
  always_comb begin
    if (bus.cfg_en && (rate_cnt_r == bus.cfg_rate_div)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  always_comb begin
    prbs_s = prbs_run(lfsr_r);
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.cfg_en) begin
      rate_cnt_r <= 16'd0;
    end else if (tick_s) begin
      rate_cnt_r <= 16'd0;
    end else begin
      rate_cnt_r <= rate_cnt_r + 16'd1;
    end
  end

  // Mode shadow is held through disable; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_sh_r <= MODE_ZERO;
    end else if (tick_s) begin
      mode_sh_r <= mode_e'(bus.cfg_mode);
    end
  end

  // Pattern state advances after the current tick has used it; the increment
  // sampled on this tick takes effect from the next sample (phase-continuous)
  always_ff @(posedge clk) begin
    if (rst || !bus.cfg_en) begin
      acc_r  <= 32'h0000_0000;
      ramp_r <= RAMP_MIN;
      lfsr_r <= PRBS_SEED;
    end else if (tick_s) begin
      acc_r  <= acc_r + bus.cfg_phase_inc;
      ramp_r <= ramp_r + {{(DW-1){1'b0}}, 1'b1};
      lfsr_r <= prbs_s.state;
    end
  end

  // Stage 1: ramp/PRBS values wait here while the LUT read is in flight
  always_ff @(posedge clk) begin
    if (rst || !bus.cfg_en) begin
      vld_p1_r  <= 1'b0;
      ramp_p1_r <= '0;
      prbs_p1_r <= '0;
    end else begin
      vld_p1_r <= tick_s;
      if (tick_s) begin
        ramp_p1_r <= ramp_r;
        prbs_p1_r <= prbs_s.bits;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [31:0] phase_s;
    assign phase_s      = acc_r + chan_phase_offset(NCH, c);
    assign addr_q_s[c]  = phase_s[31 -: LUT_AW];
    assign addr_i_s[c]  = phase_s[31 -: LUT_AW] + QUARTER;
    assign ramp_c_s[c]  = ramp_p1_r + DW'(c);

    ad9363_sin_lut #(
      .DW     (DW),
      .LUT_AW (LUT_AW)
    ) u_lut (
      .clk    (clk),
      .rst    (rst),
      .addr_a (addr_i_s[c]),
      .addr_b (addr_q_s[c]),
      .data_a (lut_i_s[c]),
      .data_b (lut_q_s[c])
    );
  end

  // mode_sh_r still holds the mode captured by the tick now leaving stage 1
  always_comb begin
    mux_i_s = '0;
    mux_q_s = '0;
    for (int c = 0; c < NCH; c++) begin
      case (mode_sh_r)
        MODE_TONE: begin
          mux_i_s[c*DW +: DW] = lut_i_s[c];
          mux_q_s[c*DW +: DW] = lut_q_s[c];
        end
        MODE_RAMP: begin
          mux_i_s[c*DW +: DW] = ramp_c_s[c];
          mux_q_s[c*DW +: DW] = ~ramp_c_s[c];
        end
        MODE_PRBS: begin
          mux_i_s[c*DW +: DW] = prbs_p1_r[2*DW-1 -: DW];
          mux_q_s[c*DW +: DW] = prbs_p1_r[DW-1:0];
        end
        default: begin
          mux_i_s[c*DW +: DW] = '0;
          mux_q_s[c*DW +: DW] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.cfg_en) begin
      valid_r  <= 1'b0;
      data_i_r <= '0;
      data_q_r <= '0;
      cnt_r    <= 32'd0;
    end else begin
      valid_r <= vld_p1_r;
      if (vld_p1_r) begin
        data_i_r <= mux_i_s;
        data_q_r <= mux_q_s;
        cnt_r    <= cnt_r + 32'd1;
      end
    end
  end

  assign bus.dac_valid  = valid_r;
  assign bus.dac_data_i = data_i_r;
  assign bus.dac_data_q = data_q_r;
  assign bus.sample_cnt = cnt_r;

endmodule

// File: tb/tb_ad9363_pattern_gen.sv
// Directed, table-driven bench for ad9363_pattern_gen (DW=12, NCH=2, LUT_AW=10).
module tb_ad9363_pattern_gen;

  localparam int DW     = 12;
  localparam int NCH    = 2;
  localparam int LUT_AW = 10;
  localparam int MAXS   = 4200;

  typedef struct {
    int k;
    int i0;
    int q0;
    int i1;
    int q1;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  int s_i0 [MAXS];
  int s_q0 [MAXS];
  int s_i1 [MAXS];
  int s_q1 [MAXS];
  int s_cnt[MAXS];
  int s_cyc[MAXS];
  int n_got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ad9363_pattern_gen_if #(.DW(DW), .NCH(NCH)) bus ();

  ad9363_pattern_gen #(.DW(DW), .NCH(NCH), .LUT_AW(LUT_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_i(input int c);
    logic [DW-1:0] v;
    v = bus.dac_data_i[c*DW +: DW];
    return int'($signed(v));
  endfunction

  function automatic int get_q(input int c);
    logic [DW-1:0] v;
    v = bus.dac_data_q[c*DW +: DW];
    return int'($signed(v));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, longint'(bus.dac_valid), 0);
    check({name, "_data"}, longint'({bus.dac_data_i, bus.dac_data_q}), 0);
    check({name, "_cnt"}, longint'(bus.sample_cnt), 0);
  endtask

  // Gathers n valid samples, giving up after budget cycles
  task automatic collect(input int n, input int budget);
    n_got = 0;
    for (int k = 0; k < budget && n_got < n; k++) begin
      step();
      if (bus.dac_valid === 1'b1) begin
        s_i0[n_got]  = get_i(0);
        s_q0[n_got]  = get_q(0);
        s_i1[n_got]  = get_i(1);
        s_q1[n_got]  = get_q(1);
        s_cnt[n_got] = int'(bus.sample_cnt);
        s_cyc[n_got] = cyc;
        n_got++;
      end
    end
    check("collect_count", n_got, n);
  endtask

  task automatic check_vec(input string name, input int idx, input vec_t v);
    check({name, "_i0"}, s_i0[idx], v.i0);
    check({name, "_q0"}, s_q0[idx], v.q0);
    check({name, "_i1"}, s_i1[idx], v.i1);
    check({name, "_q1"}, s_q1[idx], v.q1);
  endtask

  function automatic int count_bad_gaps(input int gap);
    int bad = 0;
    for (int k = 1; k < n_got; k++) begin
      if (s_cyc[k] - s_cyc[k-1] != gap) bad++;
    end
    return bad;
  endfunction

  // Reference PRBS-15: shift 24 bits, first bit ends up as the MSB of I
  task automatic prbs_model(inout logic [14:0] st, output int i, output int q);
    logic [23:0] w;
    logic        nb;
    w = '0;
    for (int b = 0; b < 24; b++) begin
      nb = st[14] ^ st[13];
      st = {st[13:0], nb};
      w  = {w[22:0], nb};
    end
    i = int'($signed(w[23:12]));
    q = int'($signed(w[11:0]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ramp_tab [6];
    vec_t tone_tab [8];
    vec_t pinc_tab [4];
    int   start;
    int   bad;
    int   last_cyc;
    int   lat;
    int   mi;
    int   mq;
    logic [14:0] st;

    ramp_tab[0] = '{0,    -2048,  2047, -2047,  2046};
    ramp_tab[1] = '{1,    -2047,  2046, -2046,  2045};
    ramp_tab[2] = '{2,    -2046,  2045, -2045,  2044};
    ramp_tab[3] = '{2047,    -1,     0,     0,    -1};
    ramp_tab[4] = '{4095,  2047, -2048, -2048,  2047};
    ramp_tab[5] = '{4096, -2048,  2047, -2047,  2046};

    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0:       tone_tab[k] = '{k,  2047,     0, -2047,     0};
        1:       tone_tab[k] = '{k,     0,  2047,     0, -2047};
        2:       tone_tab[k] = '{k, -2047,     0,  2047,     0};
        default: tone_tab[k] = '{k,     0, -2047,     0,  2047};
      endcase
    end

    pinc_tab[0] = '{0,  2047,     0, -2047,     0};
    pinc_tab[1] = '{1,  1447,  1447, -1447, -1447};
    pinc_tab[2] = '{2,     0,  2047,     0, -2047};
    pinc_tab[3] = '{3, -1447,  1447,  1447, -1447};

    rst               = 1'b1;
    bus.cfg_en        = 1'b0;
    bus.cfg_mode      = 2'd0;
    bus.cfg_phase_inc = 32'h0000_0000;
    bus.cfg_rate_div  = 16'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle("reset");
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check_idle("idle");
    end

    // Ramp, rate_div=0: continuous samples, full wrap after 4096
    bus.cfg_mode     = 2'd2;
    bus.cfg_rate_div = 16'd0;
    bus.cfg_en       = 1'b1;
    start = cyc;
    collect(4097, 4200);
    check("ramp_latency", s_cyc[0] - start, 2);
    check("ramp_gaps", count_bad_gaps(1), 0);
    foreach (ramp_tab[t]) check_vec("ramp", ramp_tab[t].k, ramp_tab[t]);
    bad = 0;
    for (int k = 0; k < n_got; k++) begin
      if (s_cnt[k] != k + 1) bad++;
    end
    check("ramp_sample_cnt", bad, 0);

    // Mid-operation reset: nothing emerges from the pipeline
    rst = 1'b1;
    step();
    check("midrst_valid1", longint'(bus.dac_valid), 0);
    rst = 1'b0;
    step();
    check("midrst_valid2", longint'(bus.dac_valid), 0);
    bus.cfg_en = 1'b0;
    step();
    check_idle("disable");

    // Tone, quarter-turn steps, rate_div=3
    bus.cfg_mode      = 2'd1;
    bus.cfg_phase_inc = 32'h4000_0000;
    bus.cfg_rate_div  = 16'd3;
    bus.cfg_en        = 1'b1;
    start = cyc;
    collect(8, 60);
    check("tone_latency", s_cyc[0] - start, 5);
    check("tone_gaps", count_bad_gaps(4), 0);
    foreach (tone_tab[t]) check_vec("tone", tone_tab[t].k, tone_tab[t]);

    // Increment halved between ticks: continues from acc=0, then 45 degree steps
    last_cyc          = s_cyc[7];
    bus.cfg_phase_inc = 32'h2000_0000;
    collect(4, 40);
    check("pinc_gap", s_cyc[0] - last_cyc, 4);
    foreach (pinc_tab[t]) check_vec("pinc", pinc_tab[t].k, pinc_tab[t]);
    check("pinc_cnt", s_cnt[3], 12);

    // Ramp to zero mid-stream: the sample already in stage 1 stays ramp
    bus.cfg_en = 1'b0;
    step();
    bus.cfg_mode     = 2'd2;
    bus.cfg_rate_div = 16'd0;
    bus.cfg_en       = 1'b1;
    collect(5, 20);
    check("msw_pre_i0", s_i0[4], -2044);
    bus.cfg_mode = 2'd0;
    collect(3, 10);
    check_vec("msw_last_ramp", 0, '{5, -2043, 2042, -2042, 2041});
    check_vec("msw_zero1", 1, '{6, 0, 0, 0, 0});
    check_vec("msw_zero2", 2, '{7, 0, 0, 0, 0});
    check("msw_cnt0", s_cnt[0], 6);
    check("msw_cnt1", s_cnt[1], 7);
    check("msw_cnt2", s_cnt[2], 8);

    // One-cycle enable drop mid-tone
    bus.cfg_en = 1'b0;
    step();
    bus.cfg_mode      = 2'd1;
    bus.cfg_phase_inc = 32'h4000_0000;
    bus.cfg_rate_div  = 16'd3;
    bus.cfg_en        = 1'b1;
    collect(3, 40);
    bus.cfg_en = 1'b0;
    start = cyc;
    step();
    check_idle("endrop");
    bus.cfg_en = 1'b1;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      step();
      if (bus.dac_valid === 1'b1) lat = cyc - start;
    end
    check("endrop_latency", lat, 6);
    check("endrop_i0", get_i(0), 2047);
    check("endrop_q0", get_q(0), 0);
    check("endrop_i1", get_i(1), -2047);
    check("endrop_cnt", longint'(bus.sample_cnt), 1);

    // PRBS, rate_div=1
    bus.cfg_en = 1'b0;
    step();
    bus.cfg_mode     = 2'd3;
    bus.cfg_rate_div = 16'd1;
    bus.cfg_en       = 1'b1;
    collect(3, 20);
    check("prbs_gaps", count_bad_gaps(2), 0);
    check("prbs_first_i", s_i0[0], 0);
    check("prbs_first_q", s_q0[0], 512);
    st = 15'h7FFF;
    for (int k = 0; k < 3; k++) begin
      prbs_model(st, mi, mq);
      check("prbs_i0", s_i0[k], mi);
      check("prbs_q0", s_q0[k], mq);
      check("prbs_i1", s_i1[k], mi);
      check("prbs_q1", s_q1[k], mq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ad9363_pattern_gen.md
# ad9363_pattern_gen

Parametrised multi-channel transmit pattern generator for the AD9363 DAC path. It produces I/Q test samples at a programmable sample rate in one of four modes: zero, DDS tone, complementary ramp or PRBS. Per-channel phase/offset staggering makes MIMO channels distinguishable. It sits between the register/config interface and the DAC data port of the AD9363 interface core, replacing the fixed-tone loop-test generator.

## Interface
- DW, 12: sample width per I or Q (signed, two's complement)
- NCH, 2: channel count (1..4)
- LUT_AW, 10: sine LUT address width (full-cycle table, 2^LUT_AW entries)
- clk  in  1  sample-domain clock
- rst  in  1  reset, synchronous, active-high; clock clk
- cfg_en  in  1  generator enable
- cfg_mode  in  2  0=zero, 1=tone, 2=ramp, 3=PRBS
- cfg_phase_inc  in  32  DDS phase increment per sample
- cfg_rate_div  in  16  sample tick every cfg_rate_div+1 clocks
- dac_valid  out  1  one-cycle strobe per output sample
- dac_data_i  out  NCH*DW  channel c at bits [c*DW +: DW]
- dac_data_q  out  NCH*DW  same packing
- sample_cnt  out  32  samples emitted since enable, wraps

## Operation
- Rate counter counts 0..cfg_rate_div and raises tick at terminal count. It is cleared while cfg_en=0.
- Config shadowing: cfg_mode and cfg_phase_inc are sampled into shadow registers only on tick. Changes between ticks never produce a mixed sample.
- Phase accumulator acc (32 b) advances by shadow phase_inc on each tick. It is not reset on an increment change (phase-continuous) and wraps modulo 2^32.
- Tone: channel c index = (acc + c*2^32/NCH)[31 -: LUT_AW].
  - Q = sin(index); I = sin(index + 2^(LUT_AW-2)), i.e. cos.
  - LUT value = round(A*sin(2πk/2^LUT_AW)) with A = 2^(DW-1)-1.
- Ramp: I counter runs -2^(DW-1) up to 2^(DW-1)-1 and then wraps to -2^(DW-1). Q = ~I (complementary, runs 2^(DW-1)-1 down). Channel c adds c to I before output (modulo 2^DW). Counters advance on tick.
- PRBS: PRBS-15 (x^15+x^14+1) LFSR, seed 15'h7FFF, advances DW*2 bits per tick. I = first DW bits, Q = next DW bits. All channels share the value.
- Zero mode: data 0, dac_valid still strobes.
- cfg_en=0 behaviour:
  - The next cycle forces dac_valid=0 and data=0.
  - acc, ramp, LFSR, sample_cnt and the rate counter return to their reset values, so re-enable restarts deterministically.
- sample_cnt increments on each dac_valid.

## Timing
- Reset values:
  - dac_valid=0, dac_data_i/q=0, sample_cnt=0.
  - acc=0, ramp I=-2^(DW-1), LFSR=7FFF, rate counter=0, shadow mode=0, shadow phase_inc=0.
- Pipeline: tick at cycle t → LUT read registered at t+1 → output register at t+2. dac_valid is high for exactly cycle t+2.
- Ramp, PRBS and zero paths are delayed to the same 2-cycle latency, so all modes align.
- First tick after enable occurs cfg_rate_div+1 cycles after cfg_en rises. It uses acc=0 and the initial ramp/LFSR values, and the sample uses the config shadowed on that tick.
- cfg_rate_div=0 gives dac_valid high every cycle.
- cfg_rate_div written mid-period: the new terminal count is compared immediately. If the counter already exceeds the new value, it wraps at 16-bit overflow, and no tick is lost beyond that period.
- A mode change takes effect on the first sample whose tick shadowed it. Samples already in the pipeline finish in the old mode.
- rst has priority over cfg_en. Mid-operation rst clears the pipeline; no dac_valid appears 1-2 cycles later.

## Structure
- Shared package ad9363_pkg: mode encodings (MODE_ZERO/TONE/RAMP/PRBS), PRBS-15 seed and taps, helper function for the channel phase offset 2^32/NCH.
- Sub-module ad9363_sin_lut: dual-read-port ROM with 2^LUT_AW × DW entries. It takes two addresses and gives registered outputs with 1-cycle latency, instantiated once per channel. Contents are generated at elaboration from the amplitude formula.
- Top holds the rate counter, shadow registers, accumulator, ramp and LFSR, mode mux and output register.

## Test plan
- Reset/idle: assert rst 3 cycles, cfg_en=0 → dac_valid=0, all data 0, sample_cnt=0 throughout.
- Ramp, DW=12, NCH=2, rate_div=0: first samples are I0=-2048,-2047,… and Q0=2047,2046,…; I1=I0+1; after 4096 samples I0 wraps 2047→-2048; dac_valid is continuous.
- Tone, LUT_AW=10, phase_inc=32'h4000_0000, rate_div=3: dac_valid every 4th cycle, 2 cycles after each tick. Ch0 I sequence 2047,0,-2047,0 repeating, Q 0,2047,0,-2047. Ch1 (offset 180°) is negated.
- phase_inc change 2^30→2^29 between ticks: next sample continues from the current acc with no jump, then steps of 45°; no glitch sample.
- Mode switch ramp→zero mid-stream: samples already in the pipeline stay ramp; the first zero sample follows the next tick; sample_cnt stays monotonic.
- cfg_en drop for one cycle mid-tone: outputs 0 the next cycle. After re-enable, the first sample appears rate_div+3 cycles later with acc=0 (I=2047, Q=0) and sample_cnt restarted at 0→1.
